os_checker_mlane: RTL and testbench
===================================

OS_CHECKER_MLANE -- requirements
Module: os_checker_mlane

Interface
REQ-001 SHALL have parameter LANES, default 4, number of independently checked lanes (1..16).
REQ-002 SHALL have parameter DEVICETYPE, default 0, 0 = downstream port, 1 = upstream port.
REQ-003 SHALL have parameter CNT_W, default 5, width of per-lane consecutive-match counter and req_count.
REQ-004 SHALL have ports: clk  in  1  sole clock, rising edge; reset  in  1  asynchronous, active-low.
REQ-005 SHALL have ports: substate  in  4  LTSSM substate code; link_number  in  8  expected link number; lane_numbers  in  8*LANES  expected lane number per lane.
REQ-006 SHALL have ports: orderedset  in  128*LANES  one ordered set per lane; valid  in  LANES  per-lane qualifier; lane_enable  in  LANES  lanes participating.
REQ-007 SHALL have ports: req_count  in  CNT_W  consecutive matches required.
REQ-008 SHALL have outputs: lane_done  out  LANES  per-lane sticky done; all_done  out  1  aggregate done; rate_id  out  8  captured rate identifier; upconfig_cap  out  1  captured upconfigure bit.

Function
REQ-009 SHALL decode fields: link = bits [15:8], lane = [23:16], rate = [39:32], upcfg = bit 42, compliance-skip = bit 43, ident = [87:80].
REQ-010 SHALL apply match rules per substate. pollingActive: link=PAD, lane=PAD, and one of: (TS1, bit43=0), (TS1, bit42=1), or TS2. pollingConfiguration: PAD/PAD, TS2.
REQ-011 SHALL apply cfgLinkWidthStart rules. Down: link=link_number, lane=PAD, TS1. Up: link!=PAD, lane=PAD, TS1.
REQ-012 SHALL apply cfgLinkWidthAccept rules. Up only: link=link_number, lane!=PAD, TS1. Down: no match (lane stays HUNT).
REQ-013 SHALL apply cfgLanenumWait/cfgLanenumAccept rules: link=link_number, lane=lane's lane_number; ident TS1 if DEVICETYPE=0, TS2 if 1. cfgComplete: same link/lane check, TS2.
REQ-014 Per-lane FSM SHALL have states IDLE, HUNT, COUNT, DONE. Substate outside REQ-010..013 -> IDLE, count 0.
REQ-015 HUNT + valid match -> COUNT with count=1. COUNT + valid match -> count+1. COUNT + valid non-match -> HUNT, count 0. valid=0 -> hold state and count.
REQ-016 SHALL enter DONE on the edge where the count reaches req_count. lane_done SHALL be registered, asserted the cycle after that valid, and sticky until a substate change or reset.
REQ-017 req_count=0 SHALL be treated as 1. Count SHALL saturate at req_count and never wrap.
REQ-018 In cfgComplete, a match whose rate or upcfg differs from the lane's previous matching OS SHALL restart count at 1 (it becomes the new first). In DONE, such a change SHALL clear lane_done and set count 1.
REQ-019 On any change of substate versus its registered value, all lanes SHALL go to HUNT (or IDLE per REQ-014) with count 0 and lane_done 0 in the next cycle. The OS presented in the change cycle SHALL be ignored.
REQ-020 Disabled lanes (lane_enable=0) SHALL stay IDLE with lane_done 0.
REQ-021 all_done SHALL equal (&(lane_done | ~lane_enable)) & (|lane_enable), combinational from registered lane_done.
REQ-022 rate_id/upconfig_cap SHALL capture rate/upcfg from each matching valid OS on the lowest-index enabled lane, and hold otherwise.

Reset
REQ-023 Asserting reset (low) SHALL immediately clear all lanes to IDLE, counters 0, lane_done 0, all_done 0, rate_id 8'h00, upconfig_cap 0, stored substate 4'd0.
REQ-024 Reset mid-count SHALL discard progress. After deassertion, counting SHALL restart from HUNT per current substate.

Structure
REQ-025 Package os_checker_pkg SHALL hold PAD=8'hF7, TS1_ID=8'h4A, TS2_ID=8'h45, the substate codes (detectQuiet=0 .. configurationIdle=9), and the field bit positions.
REQ-026 Per-lane logic SHALL be sub-module os_lane_checker, instantiated LANES times. The top holds substate tracking, aggregation and capture mux.

Verification
REQ-027 LANES=4, req_count=8, pollingActive, all lanes 8 valid PAD/PAD TS1 bit43=0 -> lane_done=4'hF and all_done=1 the cycle after the 8th.
REQ-028 Lane 2 sends 5 matches, 1 TS2 with link=8'h01, then 8 matches (pollingConfiguration) -> lane 2 done only after 14th OS; other lanes done after 8th.
REQ-029 DEVICETYPE=0, cfgComplete, lane 0 sends 4 TS2 rate 8'h02 then 1 with rate 8'h04 -> count restarts at 1, rate_id=8'h04, lane_done stays 0 until 7 more consistent.
REQ-030 lane_enable=4'b0011, lanes 0-1 done -> all_done=1. lane_enable=0 -> all_done=0.
REQ-031 Substate change from pollingActive to pollingConfiguration while all_done=1 -> lane_done=0 next cycle. Reset pulse at count 5 -> all outputs 0 immediately.
REQ-032 req_count=0, single match -> lane_done next cycle. Valid held 0 for 20 cycles mid-count -> count unchanged.

Source files
------------

// File: rtl/os_checker_pkg.sv
// rtl/os_checker_pkg.sv - shared constants, substate codes and field positions for the OS checker
package os_checker_pkg;

  localparam logic [7:0] PAD    = 8'hF7;
  localparam logic [7:0] TS1_ID = 8'h4A;
  localparam logic [7:0] TS2_ID = 8'h45;

  localparam logic [3:0] SS_DETECT_QUIET      = 4'd0;
  localparam logic [3:0] SS_DETECT_ACTIVE     = 4'd1;
  localparam logic [3:0] SS_POLLING_ACTIVE    = 4'd2;
  localparam logic [3:0] SS_POLLING_CONFIG    = 4'd3;
  localparam logic [3:0] SS_CFG_LW_START      = 4'd4;
  localparam logic [3:0] SS_CFG_LW_ACCEPT     = 4'd5;
  localparam logic [3:0] SS_CFG_LANENUM_WAIT  = 4'd6;
  localparam logic [3:0] SS_CFG_LANENUM_ACCEPT= 4'd7;
  localparam logic [3:0] SS_CFG_COMPLETE      = 4'd8;
  localparam logic [3:0] SS_CONFIG_IDLE       = 4'd9;

  localparam int LINK_LSB  = 8;
  localparam int LANE_LSB  = 16;
  localparam int RATE_LSB  = 32;
  localparam int UPCFG_BIT = 42;
  localparam int SKIP_BIT  = 43;
  localparam int IDENT_LSB = 80;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HUNT  = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } lane_state_e;

  // Substates in which lanes hunt for ordered sets; all others park lanes in IDLE.
  function automatic logic substate_checked(input logic [3:0] s);
    return (s >= SS_POLLING_ACTIVE) && (s <= SS_CFG_COMPLETE);
  endfunction

endpackage

// File: rtl/os_lane_checker.sv
// rtl/os_lane_checker.sv - per-lane ordered-set match rules and consecutive-match FSM
module os_lane_checker
  import os_checker_pkg::*;
#(
  parameter int DEVICETYPE = 0,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [127:0]     os,
  input  logic             valid,
  input  logic             enable,
  input  logic [3:0]       substate,
  input  logic             sub_chg,
  input  logic [7:0]       link_number,
  input  logic [7:0]       lane_number,
  input  logic [CNT_W-1:0] req_count,
  output logic             lane_done,
  output logic             os_hit
);

  lane_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, req_eff, cnt_next;
  logic [7:0]       rate_q, rate_d;
  logic             upcfg_q, upcfg_d;
  logic [7:0]       f_link, f_lane, f_rate, f_ident;
  logic             f_upcfg, f_skip, pad_pad, link_lane, is_match, active, restart;
  logic             unused_bits;

  assign f_link      = os[LINK_LSB +: 8];
  assign f_lane      = os[LANE_LSB +: 8];
  assign f_rate      = os[RATE_LSB +: 8];
  assign f_upcfg     = os[UPCFG_BIT];
  assign f_skip      = os[SKIP_BIT];
  assign f_ident     = os[IDENT_LSB +: 8];
  assign unused_bits = ^{os[127:88], os[79:44], os[41:40], os[31:24], os[7:0]};

  assign pad_pad   = (f_link == PAD) && (f_lane == PAD);
  assign link_lane = (f_link == link_number) && (f_lane == lane_number);
  assign req_eff   = (req_count == '0) ? CNT_W'(1) : req_count;
  assign active    = enable && substate_checked(substate);
  assign os_hit    = valid && is_match && active && !sub_chg;
  assign lane_done = (state_q == ST_DONE);

  always_comb begin
    is_match = 1'b0;
    case (substate)
      SS_POLLING_ACTIVE:
        is_match = pad_pad && ((f_ident == TS2_ID) || ((f_ident == TS1_ID) && (!f_skip || f_upcfg)));
      SS_POLLING_CONFIG:
        is_match = pad_pad && (f_ident == TS2_ID);
      SS_CFG_LW_START:
        is_match = (f_lane == PAD) && (f_ident == TS1_ID) &&
                   ((DEVICETYPE == 0) ? (f_link == link_number) : (f_link != PAD));
      SS_CFG_LW_ACCEPT:
        is_match = (DEVICETYPE == 1) && (f_link == link_number) && (f_lane != PAD) && (f_ident == TS1_ID);
      SS_CFG_LANENUM_WAIT, SS_CFG_LANENUM_ACCEPT:
        is_match = link_lane && (f_ident == ((DEVICETYPE == 0) ? TS1_ID : TS2_ID));
      SS_CFG_COMPLETE:
        is_match = link_lane && (f_ident == TS2_ID);
      default:
        is_match = 1'b0;
    endcase
  end

  // In cfgComplete a rate/upcfg change makes the current OS the new first of a run.
  always_comb begin
    restart  = (state_q == ST_IDLE) || (state_q == ST_HUNT) ||
               ((substate == SS_CFG_COMPLETE) && ((f_rate != rate_q) || (f_upcfg != upcfg_q)));
    cnt_next = restart ? CNT_W'(1) : ((cnt_q >= req_eff) ? req_eff : cnt_q + CNT_W'(1));
    state_d  = state_q;
    cnt_d    = cnt_q;
    rate_d   = rate_q;
    upcfg_d  = upcfg_q;
    if (!active) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (sub_chg) begin
      state_d = ST_HUNT;
      cnt_d   = '0;
    end else if (valid) begin
      if (is_match) begin
        rate_d  = f_rate;
        upcfg_d = f_upcfg;
        cnt_d   = cnt_next;
        state_d = (cnt_next >= req_eff) ? ST_DONE : ST_COUNT;
      end else if ((state_q == ST_COUNT) || (state_q == ST_IDLE)) begin
        state_d = ST_HUNT;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rate_q  <= '0;
      upcfg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rate_q  <= rate_d;
      upcfg_q <= upcfg_d;
    end
  end

endmodule

// File: rtl/os_checker_mlane.sv
// rtl/os_checker_mlane.sv - multi-lane ordered-set checker: substate tracking, aggregation, capture
module os_checker_mlane
  import os_checker_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int DEVICETYPE = 0,
  parameter int CNT_W      = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           substate,
  input  logic [7:0]           link_number,
  input  logic [8*LANES-1:0]   lane_numbers,
  input  logic [128*LANES-1:0] orderedset,
  input  logic [LANES-1:0]     valid,
  input  logic [LANES-1:0]     lane_enable,
  input  logic [CNT_W-1:0]     req_count,
  output logic [LANES-1:0]     lane_done,
  output logic                 all_done,
  output logic [7:0]           rate_id,
  output logic                 upconfig_cap
);

  logic [3:0]       substate_q, substate_d;
  logic [7:0]       rate_id_q, rate_id_d;
  logic             upcfg_q, upcfg_d;
  logic             sub_chg, found;
  logic [LANES-1:0] lane_hit;

  assign sub_chg = (substate != substate_q);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    os_lane_checker #(
      .DEVICETYPE (DEVICETYPE),
      .CNT_W      (CNT_W)
    ) u_lane (
      .clk         (clk),
      .reset       (reset),
      .os          (orderedset[128*g +: 128]),
      .valid       (valid[g]),
      .enable      (lane_enable[g]),
      .substate    (substate),
      .sub_chg     (sub_chg),
      .link_number (link_number),
      .lane_number (lane_numbers[8*g +: 8]),
      .req_count   (req_count),
      .lane_done   (lane_done[g]),
      .os_hit      (lane_hit[g])
    );
  end

  // Only the lowest-index enabled lane feeds the captured rate/upcfg.
  always_comb begin
    substate_d = substate;
    rate_id_d  = rate_id_q;
    upcfg_d    = upcfg_q;
    found      = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (!found && lane_enable[i]) begin
        found = 1'b1;
        if (lane_hit[i]) begin
          rate_id_d = orderedset[128*i + RATE_LSB +: 8];
          upcfg_d   = orderedset[128*i + UPCFG_BIT];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      substate_q <= SS_DETECT_QUIET;
      rate_id_q  <= 8'h00;
      upcfg_q    <= 1'b0;
    end else begin
      substate_q <= substate_d;
      rate_id_q  <= rate_id_d;
      upcfg_q    <= upcfg_d;
    end
  end

  assign all_done     = (&(lane_done | ~lane_enable)) & (|lane_enable);
  assign rate_id      = rate_id_q;
  assign upconfig_cap = upcfg_q;

endmodule

// File: tb/tb_os_checker_mlane.sv
// tb/tb_os_checker_mlane.sv - scoreboard bench for os_checker_mlane
module tb_os_checker_mlane;
  import os_checker_pkg::*;

  localparam int LANES = 4;
  localparam int CNT_W = 5;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [3:0]           substate;
  logic [7:0]           link_number;
  logic [8*LANES-1:0]   lane_numbers;
  logic [128*LANES-1:0] orderedset;
  logic [LANES-1:0]     valid, lane_enable, lane_done;
  logic [CNT_W-1:0]     req_count;
  logic                 all_done, upconfig_cap;
  logic [7:0]           rate_id;

  always #5 clk = ~clk;

  os_checker_mlane #(.LANES(LANES), .DEVICETYPE(0), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .substate(substate), .link_number(link_number),
    .lane_numbers(lane_numbers), .orderedset(orderedset), .valid(valid),
    .lane_enable(lane_enable), .req_count(req_count), .lane_done(lane_done),
    .all_done(all_done), .rate_id(rate_id), .upconfig_cap(upconfig_cap)
  );

  typedef struct {
    string      tag;
    logic [3:0] done;
    logic       all;
    logic [7:0] rate;
    logic       up;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_rate;
  logic       exp_up;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] mk_os(input logic [7:0] lk, input logic [7:0] ln, input logic [7:0] rt,
                                         input logic up, input logic sk, input logic [7:0] id);
    logic [127:0] o;
    o = '0;
    o[15:8] = lk; o[23:16] = ln; o[39:32] = rt; o[42] = up; o[43] = sk; o[87:80] = id;
    return o;
  endfunction

  task automatic set_all(input logic [127:0] o);
    for (int i = 0; i < LANES; i++) orderedset[128*i +: 128] = o;
  endtask

  task automatic set_cc(input logic [7:0] rt);
    for (int i = 0; i < LANES; i++) orderedset[128*i +: 128] = mk_os(8'h05, 8'(i), rt, 1'b0, 1'b0, TS2_ID);
  endtask

  // Inputs are already applied; the expectation refers to outputs after the next rising edge.
  task automatic tick(input string tag, input logic [3:0] exp_done);
    exp_t e;
    e.tag  = tag;
    e.done = exp_done;
    e.all  = (&(exp_done | ~lane_enable)) & (|lane_enable);
    e.rate = exp_rate;
    e.up   = exp_up;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, "_done"}, 32'(lane_done), 32'(e.done));
      check({e.tag, "_all"}, 32'(all_done), 32'(e.all));
      check({e.tag, "_rate"}, 32'(rate_id), 32'(e.rate));
      check({e.tag, "_up"}, 32'(upconfig_cap), 32'(e.up));
    end
  end

  initial begin
    reset = 1'b0; substate = SS_POLLING_ACTIVE; link_number = 8'h05;
    lane_numbers = {8'd3, 8'd2, 8'd1, 8'd0}; orderedset = '0; valid = '0;
    lane_enable = 4'hF; req_count = 5'd8; exp_rate = 8'h00; exp_up = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_done", 32'(lane_done), 0);
    check("rst_all", 32'(all_done), 0);
    check("rst_rate", 32'(rate_id), 0);
    check("rst_up", 32'(upconfig_cap), 0);
    reset = 1'b1;
    tick("pa_enter", 4'h0);

    // pollingActive: eight PAD/PAD TS1 on every lane
    set_all(mk_os(PAD, PAD, 8'h01, 1'b0, 1'b0, TS1_ID));
    valid = 4'hF; exp_rate = 8'h01;
    for (int k = 1; k <= 8; k++) tick($sformatf("pa_ts1_%0d", k), (k == 8) ? 4'hF : 4'h0);
    valid = 4'h0;
    tick("pa_sticky", 4'hF);

    // substate change clears done; the OS in the change cycle must not count or be captured
    substate = SS_POLLING_CONFIG;
    set_all(mk_os(PAD, PAD, 8'h09, 1'b0, 1'b0, TS2_ID));
    valid = 4'hF;
    tick("pc_enter", 4'h0);

    // lane 2 broken by a TS2 carrying link 01 after five matches
    set_all(mk_os(PAD, PAD, 8'h03, 1'b0, 1'b0, TS2_ID));
    exp_rate = 8'h03;
    for (int k = 1; k <= 14; k++) begin
      orderedset[128*2 +: 128] = (k == 6) ? mk_os(8'h01, PAD, 8'h03, 1'b0, 1'b0, TS2_ID)
                                          : mk_os(PAD, PAD, 8'h03, 1'b0, 1'b0, TS2_ID);
      tick($sformatf("pc_ts2_%0d", k), (k == 14) ? 4'hF : ((k >= 8) ? 4'b1011 : 4'h0));
    end

    valid = 4'h0;
    lane_enable = 4'b0011;
    tick("en_0011", 4'b0011);
    lane_enable = 4'b0000;
    tick("en_none", 4'h0);
    lane_enable = 4'hF;
    tick("en_all_idle", 4'h0);

    // cfgComplete on lane 0: rate change restarts the run
    substate = SS_CFG_COMPLETE;
    tick("cc_enter", 4'h0);
    valid = 4'b0001;
    set_cc(8'h02); exp_rate = 8'h02;
    for (int k = 1; k <= 4; k++) tick($sformatf("cc_r2_%0d", k), 4'h0);
    set_cc(8'h04); exp_rate = 8'h04;
    tick("cc_rate_chg", 4'h0);
    valid = 4'h0;
    for (int k = 1; k <= 20; k++) tick($sformatf("cc_hold_%0d", k), 4'h0);
    valid = 4'b0001;
    for (int k = 1; k <= 7; k++) tick($sformatf("cc_r4_%0d", k), (k == 7) ? 4'b0001 : 4'h0);
    set_cc(8'h02); exp_rate = 8'h02;
    tick("cc_done_chg", 4'h0);

    // req_count 0 acts as 1; compliance-skip TS1 only matches with upcfg set
    req_count = 5'd0; substate = SS_POLLING_ACTIVE; valid = 4'h0;
    tick("pa2_enter", 4'h0);
    valid = 4'hF;
    set_all(mk_os(PAD, PAD, 8'h05, 1'b0, 1'b1, TS1_ID));
    tick("pa2_skip", 4'h0);
    set_all(mk_os(PAD, PAD, 8'h05, 1'b1, 1'b1, TS1_ID));
    exp_rate = 8'h05; exp_up = 1'b1;
    tick("pa2_req0", 4'hF);

    // reset pulse at count 5 discards progress
    req_count = 5'd8; substate = SS_POLLING_CONFIG; valid = 4'h0;
    tick("pc2_enter", 4'h0);
    set_all(mk_os(PAD, PAD, 8'h06, 1'b1, 1'b0, TS2_ID));
    valid = 4'hF; exp_rate = 8'h06; exp_up = 1'b1;
    for (int k = 1; k <= 5; k++) tick($sformatf("pc2_%0d", k), 4'h0);
    #2 reset = 1'b0;
    #1;
    check("rst2_done", 32'(lane_done), 0);
    check("rst2_all", 32'(all_done), 0);
    check("rst2_rate", 32'(rate_id), 0);
    check("rst2_up", 32'(upconfig_cap), 0);
    @(negedge clk);
    reset = 1'b1; valid = 4'h0; exp_rate = 8'h00; exp_up = 1'b0;
    tick("rst2_enter", 4'h0);
    valid = 4'hF; exp_rate = 8'h06; exp_up = 1'b1;
    for (int k = 1; k <= 8; k++) tick($sformatf("rst2_ts2_%0d", k), (k == 8) ? 4'hF : 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
